// File: rtl/leaf_pkt_pkg.sv
// Purpose: shared packet field positions, widths and FSM state type for the BFT leaf receiver.
// Ports: none (package).
// Contents: bit-position constants, packet/payload widths, rx_state_e.
package leaf_pkt_pkg;

  localparam int PKT_W       = 49;
  localparam int PAYLOAD_W   = 32;

  localparam int VALID_BIT   = 48;
  localparam int LEAF_HI     = 47;
  localparam int LEAF_LO     = 43;
  localparam int PORT_HI     = 42;
  localparam int PORT_LO     = 39;
  localparam int RSVD_HI     = 38;
  localparam int RSVD_LO     = 32;
  localparam int PAYLOAD_HI  = 31;
  localparam int PAYLOAD_LO  = 0;

  localparam int LEAF_W      = LEAF_HI - LEAF_LO + 1;
  localparam int PORT_W      = PORT_HI - PORT_LO + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/leaf_bft_rx_if.sv
// Purpose: one operator output stream (payload + valid/ready handshake).
// Ports: data/valid driven by master, ready driven by slave.
// Modports: master (buffer side), slave (operator side).
interface leaf_bft_rx_if;
  import leaf_pkt_pkg::*;

  logic [PAYLOAD_W-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/leaf_rx_fifo.sv
// Purpose: per-port first-word-fall-through buffer feeding one operator stream.
// Ports: clk, reset, push/push_data/full (write side), out (stream master modport).
// Latency: a word pushed at edge k is on out.data after edge k; no combinational bypass.
module leaf_rx_fifo #(
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  leaf_bft_rx_if.master    out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  // Full is judged on current occupancy, so a same-cycle pop never frees room.
  assign do_push = push && !full;
  assign do_pop  = out.valid && out.ready;

  assign out.valid = !empty;
  assign out.data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH naturally.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/leaf_bft_rx.sv
// Purpose: BFT leaf receive page: decodes leaf packets, steers them into two port buffers, counts drops.
// Ports: clk, reset, ap_start, din_leaf_bft2interface, dout0/1 data/valid/ready, resend_req/resend_port, drop_cnt, running.
// Latency: accepted packet visible on doutN one cycle later; overflow resend_req pulses the cycle after the drop.
module leaf_bft_rx
  import leaf_pkt_pkg::*;
#(
  parameter logic [4:0] LEAF_ADDR  = 5'd0,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ap_start,
  input  logic [PKT_W-1:0]     din_leaf_bft2interface,
  output logic [PAYLOAD_W-1:0] dout0_data,
  output logic                 dout0_valid,
  input  logic                 dout0_ready,
  output logic [PAYLOAD_W-1:0] dout1_data,
  output logic                 dout1_valid,
  input  logic                 dout1_ready,
  output logic                 resend_req,
  output logic [3:0]           resend_port,
  output logic [15:0]          drop_cnt,
  output logic                 running
);

  rx_state_e state, state_nxt;

  logic                 pkt_valid;
  logic [LEAF_W-1:0]    pkt_leaf;
  logic [PORT_W-1:0]    pkt_port;
  logic [PAYLOAD_W-1:0] pkt_payload;

  logic full0, full1;
  logic push0, push1;
  logic addr_hit;
  logic overflow;
  logic drop;

  leaf_bft_rx_if s0_if ();
  leaf_bft_rx_if s1_if ();

  // Reserved bits [38:32] carry no meaning for this page and are not decoded.
  assign pkt_valid   = din_leaf_bft2interface[VALID_BIT];
  assign pkt_leaf    = din_leaf_bft2interface[LEAF_HI:LEAF_LO];
  assign pkt_port    = din_leaf_bft2interface[PORT_HI:PORT_LO];
  assign pkt_payload = din_leaf_bft2interface[PAYLOAD_HI:PAYLOAD_LO];

  // FSM: leaves IDLE once ap_start is seen; only reset returns it to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    running   = 1'b0;
    case (state)
      ST_IDLE: if (ap_start) state_nxt = ST_RUN;
      ST_RUN:  running = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Decode: in IDLE nothing is accepted and nothing counts as a drop.
  always_comb begin
    addr_hit = running && pkt_valid && (pkt_leaf == LEAF_ADDR) && (pkt_port <= 4'd1);
    push0    = addr_hit && (pkt_port == 4'd0) && !full0;
    push1    = addr_hit && (pkt_port == 4'd1) && !full1;
    overflow = addr_hit && ((pkt_port == 4'd0) ? full0 : full1);
    drop     = (running && pkt_valid && !addr_hit) || overflow;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt    <= '0;
      resend_req  <= 1'b0;
      resend_port <= '0;
    end else begin
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      // Only buffer overflow merits a retransmit; misrouted packets would fail again.
      resend_req <= overflow;
      if (overflow) resend_port <= pkt_port;
    end
  end

  leaf_rx_fifo #(.WIDTH(PAYLOAD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .push      (push0),
    .push_data (pkt_payload),
    .full      (full0),
    .out       (s0_if.master)
  );

  leaf_rx_fifo #(.WIDTH(PAYLOAD_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (pkt_payload),
    .full      (full1),
    .out       (s1_if.master)
  );

  assign dout0_data  = s0_if.data;
  assign dout0_valid = s0_if.valid;
  assign s0_if.ready = dout0_ready;
  assign dout1_data  = s1_if.data;
  assign dout1_valid = s1_if.valid;
  assign s1_if.ready = dout1_ready;

endmodule
